// File: rtl/scr1_dmi_target.sv
`default_nettype none
// ============================================================================
// Module   : scr1_dmi_target
// Brief    : DMI responder with a reduced DM register set and an access-register
//            abstract command engine (req/ack toward the hart, timeout guarded).
// Revision : 1.0
// ============================================================================
module scr1_dmi_target #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmi_req,
  input  logic              dmi_wr,
  input  logic [ADDR_W-1:0] dmi_addr,
  input  logic [DATA_W-1:0] dmi_wdata,
  output logic              dmi_resp,
  output logic [DATA_W-1:0] dmi_rdata,
  input  logic              hart_halted,
  input  logic              hart_resumeack,
  output logic              dm_ndmreset,
  output logic              dm_haltreq,
  output logic              dm_resumereq,
  output logic              hart_req,
  output logic              hart_wr,
  output logic [15:0]       hart_regno,
  output logic [DATA_W-1:0] hart_wdata,
  input  logic              hart_ack,
  input  logic              hart_err,
  input  logic [DATA_W-1:0] hart_rdata
);

  localparam logic [ADDR_W-1:0] c_addr_data0      = ADDR_W'(7'h04);
  localparam logic [ADDR_W-1:0] c_addr_dmcontrol  = ADDR_W'(7'h10);
  localparam logic [ADDR_W-1:0] c_addr_dmstatus   = ADDR_W'(7'h11);
  localparam logic [ADDR_W-1:0] c_addr_abstractcs = ADDR_W'(7'h16);
  localparam logic [ADDR_W-1:0] c_addr_command    = ADDR_W'(7'h17);
  localparam logic [15:0]       c_cnt_last        = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t            r_state;
  logic [15:0]       r_cnt;
  logic              r_cmd_wr;
  logic [15:0]       r_regno;
  logic [DATA_W-1:0] r_data0;
  logic              r_dmactive;
  logic              r_ndmreset;
  logic              r_haltreq;
  logic              r_resumereq;
  logic              r_resumeack;
  logic [2:0]        r_cmderr;

  logic              w_busy;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_dmactive_nxt;
  logic              w_cmd_bad;
  logic [DATA_W-1:0] w_rdata;

  assign w_busy    = (r_state == ST_REQ);
  assign w_wr_en   = dmi_req & dmi_wr;
  assign w_rd_en   = dmi_req & ~dmi_wr;
  assign w_cmd_bad = (dmi_wdata[31:24] != 8'd0) || (dmi_wdata[22:20] != 3'd2);

  // Value dmactive will hold after this edge; used to hold the gated state at 0.
  assign w_dmactive_nxt = (w_wr_en && dmi_addr == c_addr_dmcontrol) ? dmi_wdata[0] : r_dmactive;

  always_comb begin
    w_rdata = '0;
    if (w_rd_en) begin
      case (dmi_addr)
        c_addr_data0:      w_rdata = r_data0;
        c_addr_dmcontrol:  w_rdata = {r_haltreq, 1'b0, 28'd0, r_ndmreset, r_dmactive};
        c_addr_dmstatus:   w_rdata = {14'd0, {2{r_resumeack}}, 4'd0, {2{~hart_halted}},
                                      {2{hart_halted}}, 1'b1, 3'd0, 4'd2};
        c_addr_abstractcs: w_rdata = {19'd0, w_busy, 1'b0, r_cmderr, 4'd0, 4'd1};
        default:           w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 16'd0;
      r_cmd_wr    <= 1'b0;
      r_regno     <= 16'd0;
      r_data0     <= '0;
      r_dmactive  <= 1'b0;
      r_ndmreset  <= 1'b0;
      r_haltreq   <= 1'b0;
      r_resumereq <= 1'b0;
      r_resumeack <= 1'b0;
      r_cmderr    <= 3'd0;
    end else begin
      r_resumereq <= 1'b0;
      if (hart_resumeack) r_resumeack <= 1'b1;

      if (w_wr_en) begin
        case (dmi_addr)
          c_addr_data0: begin
            if (w_busy) begin
              if (r_cmderr == 3'd0) r_cmderr <= 3'd1;
            end else if (r_dmactive) begin
              r_data0 <= dmi_wdata;
            end
          end
          c_addr_dmcontrol: begin
            r_dmactive <= dmi_wdata[0];
            if (r_dmactive) begin
              r_ndmreset <= dmi_wdata[1];
              r_haltreq  <= dmi_wdata[31];
            end
            if (dmi_wdata[30] && !dmi_wdata[31]) begin
              r_resumereq <= 1'b1;
              r_resumeack <= 1'b0;
            end
          end
          c_addr_abstractcs: begin
            if (w_busy) begin
              if (r_cmderr == 3'd0) r_cmderr <= 3'd1;
            end else begin
              r_cmderr <= r_cmderr & ~dmi_wdata[10:8];
            end
          end
          c_addr_command: begin
            if (r_cmderr == 3'd0) begin
              if (w_busy) begin
                r_cmderr <= 3'd1;
              end else if (w_cmd_bad) begin
                r_cmderr <= 3'd2;
              end else if (dmi_wdata[17]) begin
                r_state  <= ST_REQ;
                r_cmd_wr <= dmi_wdata[16];
                r_regno  <= dmi_wdata[15:0];
              end
            end
          end
          default: ;
        endcase
      end

      // Hart outcome is applied after DMI effects so it wins on cmderr and DATA0.
      if (w_busy) begin
        if (hart_ack) begin
          r_state <= ST_IDLE;
          r_cnt   <= 16'd0;
          if (hart_err)       r_cmderr <= 3'd3;
          else if (!r_cmd_wr) r_data0  <= hart_rdata;
        end else if (r_cnt == c_cnt_last) begin
          r_state  <= ST_IDLE;
          r_cnt    <= 16'd0;
          r_cmderr <= 3'd3;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end

      if (!w_dmactive_nxt) begin
        r_data0    <= '0;
        r_ndmreset <= 1'b0;
        r_haltreq  <= 1'b0;
        r_cmderr   <= 3'd0;
      end
    end
  end

  assign dmi_resp     = dmi_req;
  assign dmi_rdata    = w_rdata;
  assign dm_ndmreset  = r_ndmreset;
  assign dm_haltreq   = r_haltreq;
  assign dm_resumereq = r_resumereq;
  assign hart_req     = w_busy;
  assign hart_wr      = r_cmd_wr;
  assign hart_regno   = r_regno;
  assign hart_wdata   = r_data0;

endmodule
`default_nettype wire

// File: tb/tb_scr1_dmi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_scr1_dmi_target
// Brief    : Scoreboard bench for scr1_dmi_target against a behavioural DM model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_scr1_dmi_target;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmi_req = 1'b0, dmi_wr = 1'b0;
  logic [6:0]  dmi_addr = '0;
  logic [31:0] dmi_wdata = '0;
  logic        dmi_resp;
  logic [31:0] dmi_rdata;
  logic        hart_halted = 1'b1, hart_resumeack = 1'b0;
  logic        dm_ndmreset, dm_haltreq, dm_resumereq;
  logic        hart_req, hart_wr;
  logic [15:0] hart_regno;
  logic [31:0] hart_wdata;
  logic        hart_ack = 1'b0, hart_err = 1'b0;
  logic [31:0] hart_rdata = '0;

  always #5 clk = ~clk;

  scr1_dmi_target #(.ADDR_W(7), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmi_req(dmi_req), .dmi_wr(dmi_wr), .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata),
    .dmi_resp(dmi_resp), .dmi_rdata(dmi_rdata),
    .hart_halted(hart_halted), .hart_resumeack(hart_resumeack),
    .dm_ndmreset(dm_ndmreset), .dm_haltreq(dm_haltreq), .dm_resumereq(dm_resumereq),
    .hart_req(hart_req), .hart_wr(hart_wr), .hart_regno(hart_regno), .hart_wdata(hart_wdata),
    .hart_ack(hart_ack), .hart_err(hart_err), .hart_rdata(hart_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the debug module ----------------
  logic [31:0] m_data0;
  logic [15:0] m_regno;
  logic [2:0]  m_cmderr;
  bit          m_dmactive, m_ndmreset, m_haltreq, m_resumereq, m_resumeack, m_busy, m_wr;
  int          m_wait;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [15:0] regno;
    logic [31:0] wdata;
    logic        ndm;
    logic        halt;
    logic        resume;
  } out_t;

  logic [31:0] rdq[$];
  out_t        outq[$];
  bit          mon_en = 1'b0;

  // hart responder controls
  int          ack_delay = -1;
  bit          ack_err = 1'b0;
  bit          ack_rd_fixed = 1'b0;
  logic [31:0] ack_rdata = '0;
  bit          rand_mode = 1'b0;
  bit          late_acks = 1'b0;
  bit          force_late_ack = 1'b0;

  task automatic m_reset();
    m_data0 = '0; m_regno = '0; m_cmderr = '0;
    m_dmactive = 0; m_ndmreset = 0; m_haltreq = 0; m_resumereq = 0;
    m_resumeack = 0; m_busy = 0; m_wr = 0; m_wait = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [6:0] a, input logic halted);
    logic [31:0] r;
    r = 0;
    case (a)
      7'h04: r = m_data0;
      7'h10: begin
        if (m_haltreq)  r = r + 32'h8000_0000;
        if (m_ndmreset) r = r + 32'h2;
        if (m_dmactive) r = r + 32'h1;
      end
      7'h11: begin
        r = 32'h82 + (halted ? 32'h300 : 32'hC00);
        if (m_resumeack) r = r + 32'h3_0000;
      end
      7'h16: r = 32'h1 + (32'(m_cmderr) * 32'h100) + (m_busy ? 32'h1000 : 32'h0);
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic void m_set_busy_err();
    if (m_cmderr == 0) m_cmderr = 1;
  endfunction

  // Advance the model by one clock edge using the inputs presented in that cycle.
  task automatic m_step();
    logic [31:0] wd;
    logic [6:0]  a;
    bit          wen, busy0, act_nxt, start;
    wd = dmi_wdata; a = dmi_addr;
    wen = dmi_req && dmi_wr; busy0 = m_busy; start = 0;
    act_nxt = (wen && a == 7'h10) ? wd[0] : m_dmactive;
    m_resumereq = 0;
    if (hart_resumeack) m_resumeack = 1;
    if (wen) begin
      if (a == 7'h04) begin
        if (busy0) m_set_busy_err();
        else if (m_dmactive) m_data0 = wd;
      end else if (a == 7'h10) begin
        if (m_dmactive) begin m_ndmreset = wd[1]; m_haltreq = wd[31]; end
        m_dmactive = wd[0];
        if (wd[30] && !wd[31]) begin m_resumereq = 1; m_resumeack = 0; end
      end else if (a == 7'h16) begin
        if (busy0) m_set_busy_err();
        else m_cmderr = m_cmderr & ~wd[10:8];
      end else if (a == 7'h17 && m_cmderr == 0) begin
        if (busy0) m_cmderr = 1;
        else if (wd[31:24] != 0 || wd[22:20] != 3'd2) m_cmderr = 2;
        else if (wd[17]) start = 1;
      end
    end
    if (busy0) begin
      if (hart_ack) begin
        m_busy = 0; m_wait = 0;
        if (hart_err) m_cmderr = 3;
        else if (!m_wr) m_data0 = hart_rdata;
      end else if (m_wait + 1 == TO) begin
        m_busy = 0; m_wait = 0; m_cmderr = 3;
      end else begin
        m_wait++;
      end
    end
    if (start) begin
      m_busy = 1; m_wr = wd[16]; m_regno = wd[15:0]; m_wait = 0;
      if (rand_mode) begin
        ack_delay = $urandom_range(0, TO);
        ack_err   = ($urandom_range(0, 3) == 0);
      end
    end
    if (!act_nxt) begin
      m_data0 = '0; m_ndmreset = 0; m_haltreq = 0; m_cmderr = 0;
    end
  endtask

  // One bus cycle: drive inputs, predict response, take the edge, predict outputs.
  task automatic cyc(input bit req, input bit wr, input logic [6:0] addr,
                     input logic [31:0] wd, input bit rchk = 0, input logic [31:0] rexp = 0);
    out_t o;
    hart_ack = 0; hart_err = 0; hart_rdata = $urandom;
    if (m_busy) begin
      if (ack_delay >= 0 && m_wait == ack_delay) begin
        hart_ack = 1; hart_err = ack_err;
        if (ack_rd_fixed) hart_rdata = ack_rdata;
      end
    end else if (force_late_ack || (late_acks && $urandom_range(0, 7) == 0)) begin
      hart_ack = 1; hart_err = ($urandom_range(0, 1) == 1);
      if (ack_rd_fixed) hart_rdata = ack_rdata;
    end
    dmi_req = req; dmi_wr = wr; dmi_addr = addr; dmi_wdata = wd;
    if (req) rdq.push_back(wr ? 32'h0 : m_read(addr, hart_halted));
    #1;
    if (rchk) chk("direct_read", dmi_rdata, rexp);
    @(posedge clk);
    m_step();
    o.req = m_busy; o.wr = m_wr; o.regno = m_regno; o.wdata = m_data0;
    o.ndm = m_ndmreset; o.halt = m_haltreq; o.resume = m_resumereq;
    outq.push_back(o);
    #1;
    dmi_req = 0; hart_resumeack = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 7'h00, 32'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    out_t        o;
    if (mon_en) begin
      chk("dmi_resp", {31'd0, dmi_resp}, {31'd0, dmi_req});
      if (dmi_resp) begin
        if (rdq.size() == 0) chk("rdq_underflow", 32'd1, 32'd0);
        else begin
          e = rdq.pop_front();
          chk("dmi_rdata", dmi_rdata, e);
        end
      end else begin
        chk("dmi_rdata_idle", dmi_rdata, 32'h0);
      end
      if (outq.size() != 0) begin
        o = outq.pop_front();
        chk("hart_req", {31'd0, hart_req}, {31'd0, o.req});
        chk("dm_ndmreset", {31'd0, dm_ndmreset}, {31'd0, o.ndm});
        chk("dm_haltreq", {31'd0, dm_haltreq}, {31'd0, o.halt});
        chk("dm_resumereq", {31'd0, dm_resumereq}, {31'd0, o.resume});
        if (o.req) begin
          chk("hart_wr", {31'd0, hart_wr}, {31'd0, o.wr});
          chk("hart_regno", {16'd0, hart_regno}, {16'd0, o.regno});
          chk("hart_wdata", hart_wdata, o.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rand_cmd();
    logic [31:0] c;
    c = {8'h00, 1'b0, 3'd2, 2'b00, 1'b1, ($urandom_range(0, 1) == 1), 16'($urandom)};
    case ($urandom_range(0, 5))
      0: c[31:24] = 8'($urandom_range(1, 255));
      1: c[22:20] = 3'd3;
      2: c[17]    = 1'b0;
      default: ;
    endcase
    return c;
  endfunction

  initial begin
    logic [6:0]  addrs [7];
    logic [6:0]  a;
    logic [31:0] wd;
    int          n;
    addrs = '{7'h04, 7'h10, 7'h11, 7'h16, 7'h17, 7'h00, 7'h7f};
    m_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hart_req", {31'd0, hart_req}, 32'd0);
    chk("reset_dm_outs", {29'd0, dm_ndmreset, dm_haltreq, dm_resumereq}, 32'd0);
    chk("reset_hart_bus", {15'd0, hart_wr, hart_regno} | hart_wdata, 32'd0);
    rst_n = 1;
    mon_en = 1;

    // DMSTATUS while halted
    hart_halted = 1;
    cyc(1, 0, 7'h11, 0, 1, 32'h0000_0382);
    cyc(1, 1, 7'h10, 32'h0000_0001);
    cyc(1, 0, 7'h16, 0, 1, 32'h0000_0001);

    // abstract register write
    cyc(1, 1, 7'h04, 32'hDEAD_BEEF);
    ack_delay = 2; ack_err = 0;
    cyc(1, 1, 7'h17, 32'h0023_1000);
    chk("write_cmd_req", {15'd0, hart_req, hart_regno}, {15'd0, 1'b1, 16'h1000});
    chk("write_cmd_wr", {31'd0, hart_wr}, 32'd1);
    chk("write_cmd_wdata", hart_wdata, 32'hDEAD_BEEF);
    idle(4);
    cyc(1, 0, 7'h16, 0, 1, 32'h0000_0001);

    // abstract register read
    ack_delay = 1; ack_rd_fixed = 1; ack_rdata = 32'h1234_5678;
    cyc(1, 1, 7'h17, 32'h0022_1001);
    idle(3);
    cyc(1, 0, 7'h04, 0, 1, 32'h1234_5678);

    // command while busy, then timeout, then command ignored under cmderr
    ack_delay = -1;
    cyc(1, 1, 7'h17, 32'h0022_1002);
    cyc(1, 1, 7'h17, 32'h0022_1002);
    cyc(1, 0, 7'h16, 0, 1, 32'h0000_1101);
    idle(3);
    cyc(1, 0, 7'h16, 0, 1, 32'h0000_0301);
    cyc(1, 1, 7'h17, 32'h0022_1003);
    chk("cmd_ignored", {31'd0, hart_req}, 32'd0);
    cyc(1, 1, 7'h16, 32'h0000_0700);
    cyc(1, 0, 7'h16, 0, 1, 32'h0000_0001);

    // timeout length and late ack
    cyc(1, 1, 7'h17, 32'h0022_1004);
    n = hart_req ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      idle(1);
      if (hart_req) n++;
    end
    chk("timeout_req_cycles", 32'(n), 32'd4);
    ack_rdata = 32'hCAFE_F00D; force_late_ack = 1;
    idle(1);
    force_late_ack = 0; ack_rd_fixed = 0;
    cyc(1, 0, 7'h04, 0, 1, 32'h1234_5678);
    cyc(1, 0, 7'h16, 0, 1, 32'h0000_0301);
    cyc(1, 1, 7'h16, 32'h0000_0700);

    // resume request pulse and resumeack flag
    cyc(1, 1, 7'h10, 32'h4000_0001);
    chk("resumereq_pulse", {31'd0, dm_resumereq}, 32'd1);
    idle(1);
    chk("resumereq_drop", {31'd0, dm_resumereq}, 32'd0);
    hart_resumeack = 1;
    idle(1);
    cyc(1, 0, 7'h11, 0, 1, 32'h0003_0382);

    // randomized traffic
    rand_mode = 1; late_acks = 1;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 15) == 0) hart_halted = ~hart_halted;
      hart_resumeack = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) begin
        idle(1);
      end else begin
        a  = addrs[$urandom_range(0, 6)];
        wd = $urandom;
        if (a == 7'h10) wd[0] = ($urandom_range(0, 9) != 0);
        if (a == 7'h17) wd = rand_cmd();
        if (a == 7'h16 && $urandom_range(0, 1) == 1) wd = 32'h0000_0700;
        cyc(1, ($urandom_range(0, 1) == 1), a, wd);
      end
    end

    // reset in the middle of a hart access
    rand_mode = 0; late_acks = 0; ack_delay = 0;
    idle(TO + 2);
    cyc(1, 1, 7'h10, 32'h8000_0003);
    cyc(1, 1, 7'h16, 32'h0000_0700);
    ack_delay = -1;
    cyc(1, 1, 7'h17, 32'h0023_0055);
    chk("prereset_req", {31'd0, hart_req}, 32'd1);
    mon_en = 0;
    #2 rst_n = 0;
    #1;
    chk("midreset_hart_req", {31'd0, hart_req}, 32'd0);
    chk("midreset_dm_outs", {29'd0, dm_ndmreset, dm_haltreq, dm_resumereq}, 32'd0);
    chk("midreset_hart_bus", {15'd0, hart_wr, hart_regno} | hart_wdata, 32'd0);
    chk("midreset_dmi", {31'd0, dmi_resp} | dmi_rdata, 32'd0);
    rdq.delete(); outq.delete(); m_reset();
    @(posedge clk); #1;
    rst_n = 1;
    mon_en = 1;
    cyc(1, 0, 7'h10, 0, 1, 32'h0000_0000);
    cyc(1, 0, 7'h16, 0, 1, 32'h0000_0001);
    idle(1);
    @(negedge clk); #1;
    mon_en = 0;
    chk("rdq_drained", 32'(rdq.size()), 32'd0);
    chk("outq_drained", 32'(outq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
